// File: rtl/aes_block_demux.sv
// rtl/aes_block_demux.sv - registered 1-to-4 demux for 128-bit AES state blocks
// Each channel owns a one-entry holding register with its own valid/ready handshake.

module aes_block_demux #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout_s00,
    output logic [WIDTH-1:0] dout_s01,
    output logic [WIDTH-1:0] dout_s10,
    output logic [WIDTH-1:0] dout_s11,
    output logic [3:0]       dout_valid,
    input  logic [3:0]       dout_ready,
    output logic [CNT_W-1:0] xfer_count
);

    logic             accept;
    logic [3:0]       ch_valid;
    logic [WIDTH-1:0] ch_data [4];
    logic [CNT_W-1:0] count_q;

    // A full channel still accepts when its destination drains it on the same edge.
    assign din_ready = ~ch_valid[sel] | dout_ready[sel];
    assign accept    = din_valid & din_ready;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic             load;

        assign load = accept && (sel == 2'(k));

        // Load wins over drain so a drain+load pair keeps valid high with no bubble.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (load) begin
                valid_q <= 1'b1;
                data_q  <= din;
            end else if (valid_q && dout_ready[k]) begin
                valid_q <= 1'b0;
            end
        end

        assign ch_valid[k] = valid_q;
        assign ch_data[k]  = data_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign dout_valid = ch_valid;
    assign dout_s00   = ch_data[0];
    assign dout_s01   = ch_data[1];
    assign dout_s10   = ch_data[2];
    assign dout_s11   = ch_data[3];
    assign xfer_count = count_q;

endmodule

// File: tb/tb_aes_block_demux.sv
// tb/tb_aes_block_demux.sv - directed self-checking bench for aes_block_demux

module tb_aes_block_demux;

    localparam int WIDTH = 128;
    localparam int CNT_W = 16;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout_s00, dout_s01, dout_s10, dout_s11;
    logic [3:0]       dout_valid;
    logic [3:0]       dout_ready;
    logic [CNT_W-1:0] xfer_count;

    int errors = 0;
    int checks = 0;

    localparam logic [WIDTH-1:0] BLK_TP  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [WIDTH-1:0] BLK_B1  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [WIDTH-1:0] BLK_A5  = {16{8'hA5}};
    localparam logic [WIDTH-1:0] BLK_C0  = 128'hC0C0C0C0_00000000_00000000_0000C0C0;
    localparam logic [WIDTH-1:0] BLK_C3  = 128'hC3C3C3C3_00000000_00000000_0000C3C3;
    localparam logic [WIDTH-1:0] BLK_BAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    aes_block_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .din        (din),
        .sel        (sel),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_s00   (dout_s00),
        .dout_s01   (dout_s01),
        .dout_s10   (dout_s10),
        .dout_s11   (dout_s11),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .xfer_count (xfer_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Source obligation: a stalled offer must be held unchanged until accepted.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_din;
    logic [1:0]       prev_sel;
    always @(posedge Clk) begin
        if (prev_stall && !Reset) begin
            checks++;
            if (!din_valid || din !== prev_din || sel !== prev_sel) begin
                errors++;
                $display("FAIL src_hold: din_valid=%0b sel=%0d required held sel=%0d", din_valid, sel, prev_sel);
            end
        end
        prev_stall = din_valid && !din_ready && !Reset;
        prev_din   = din;
        prev_sel   = sel;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        din_valid = 1'b0;
        dout_ready = 4'b0000;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dout_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid: got %b required 0000", dout_valid);
        end
        checks++;
        if (xfer_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", xfer_count);
        end
        checks++;
        if (dout_s00 !== '0 || dout_s01 !== '0 || dout_s10 !== '0 || dout_s11 !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h required zeros", dout_s00, dout_s01, dout_s10, dout_s11);
        end
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            checks++;
            if (din_ready !== 1'b1) begin
                errors++; $display("FAIL reset_ready sel=%0d: got %b required 1", i, din_ready);
            end
        end
        din = BLK_TP; sel = 2'b10; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 4'b0100) begin
            errors++; $display("FAIL first_valid: got %b required 0100", dout_valid);
        end
        checks++;
        if (dout_s10 !== BLK_TP) begin
            errors++; $display("FAIL first_data: got %h required %h", dout_s10, BLK_TP);
        end
        checks++;
        if (xfer_count !== 16'd1) begin
            errors++; $display("FAIL first_count: got %0d required 1", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        din = BLK_B1; sel = 2'b01; din_valid = 1'b1; dout_ready = 4'b0000;
        step();
        din = BLK_A5;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (din_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready cycle %0d: got %b required 0", i, din_ready);
            end
            step();
            checks++;
            if (dout_s01 !== BLK_B1) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %h required %h", i, dout_s01, BLK_B1);
            end
        end
        dout_ready = 4'b0010;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b required 1", din_ready);
        end
        step();
        din_valid = 1'b0; dout_ready = 4'b0000;
        checks++;
        if (dout_valid !== 4'b0110) begin
            errors++; $display("FAIL bp_valid: got %b required 0110", dout_valid);
        end
        checks++;
        if (dout_s01 !== BLK_A5) begin
            errors++; $display("FAIL bp_data: got %h required %h", dout_s01, BLK_A5);
        end
        checks++;
        if (xfer_count !== 16'd3) begin
            errors++; $display("FAIL bp_count: got %0d required 3", xfer_count);
        end
    endtask

    task automatic test_independence();
        dout_ready = 4'b0100;
        step();
        dout_ready = 4'b0000;
        checks++;
        if (dout_valid !== 4'b0010) begin
            errors++; $display("FAIL ind_drain: got %b required 0010", dout_valid);
        end
        din = BLK_C0; sel = 2'b00; din_valid = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL ind_ready0: got %b required 1", din_ready);
        end
        step();
        din = BLK_C3; sel = 2'b11;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL ind_ready3: got %b required 1", din_ready);
        end
        step();
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 4'b1011) begin
            errors++; $display("FAIL ind_valid: got %b required 1011", dout_valid);
        end
        checks++;
        if (dout_s01 !== BLK_A5 || dout_s00 !== BLK_C0 || dout_s11 !== BLK_C3) begin
            errors++; $display("FAIL ind_data: got %h %h %h", dout_s00, dout_s01, dout_s11);
        end
        checks++;
        if (xfer_count !== 16'd5) begin
            errors++; $display("FAIL ind_count: got %0d required 5", xfer_count);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        dout_ready = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            din = WIDTH'(i); sel = 2'b00; din_valid = 1'b1;
            #1;
            checks++;
            if (din_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready %0d: got %b required 1", i, din_ready);
            end
            step();
            checks++;
            if (dout_valid[0] !== 1'b1 || dout_s00 !== WIDTH'(i)) begin
                errors++; $display("FAIL stream_data %0d: got v=%b %h required v=1 %0d", i, dout_valid[0], dout_s00, i);
            end
        end
        din_valid = 1'b0;
        checks++;
        if (xfer_count !== 16'd8) begin
            errors++; $display("FAIL stream_count: got %0d required 8", xfer_count);
        end
        step();
        checks++;
        if (dout_valid !== 4'b0000) begin
            errors++; $display("FAIL stream_drain: got %b required 0000", dout_valid);
        end
        dout_ready = 4'b0000;
    endtask

    task automatic test_mid_reset();
        dout_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            din = {32'h0, 32'h0, 32'h0, 32'(i + 16'hF00)}; sel = 2'(i); din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 4'b1111) begin
            errors++; $display("FAIL mid_fill: got %b required 1111", dout_valid);
        end
        din = BLK_BAD; sel = 2'b00; din_valid = 1'b1; dout_ready = 4'b0001; Reset = 1'b1;
        step();
        Reset = 1'b0; din_valid = 1'b0; dout_ready = 4'b0000;
        checks++;
        if (dout_valid !== 4'b0000) begin
            errors++; $display("FAIL mid_valid: got %b required 0000", dout_valid);
        end
        checks++;
        if (xfer_count !== 16'd0) begin
            errors++; $display("FAIL mid_count: got %0d required 0", xfer_count);
        end
        checks++;
        if (dout_s00 !== '0) begin
            errors++; $display("FAIL mid_capture: got %h required 0", dout_s00);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        dout_ready = 4'b1111; sel = 2'b11; din_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            din = WIDTH'(i);
            step();
        end
        checks++;
        if (xfer_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_ffff: got %h required ffff", xfer_count);
        end
        step();
        checks++;
        if (xfer_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h required 0000", xfer_count);
        end
        step();
        din_valid = 1'b0;
        checks++;
        if (xfer_count !== 16'h0001) begin
            errors++; $display("FAIL wrap_one: got %h required 0001", xfer_count);
        end
    endtask

    initial begin
        Reset = 1'b1; din = '0; sel = 2'b00; din_valid = 1'b0; dout_ready = 4'b0000;
        test_reset();
        test_backpressure();
        test_independence();
        test_streaming();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
